alu_issue_ctrl: RTL and testbench

//  Drives the combinational Alu: accepts one instruction per valid/ready handshake, reads two

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the Alu issue controller.
//   OP_*          Alu opcodes understood by the controller (0..OP_MAX_VALID)
//   FLG_*         bit positions inside the {Z,C,N} status register
//   state_t       issue FSM states
//   op_is_valid   true when an opcode is one the Alu really implements
package alu_pkg;

  localparam logic [7:0] OP_AND       = 8'd0;
  localparam logic [7:0] OP_OR        = 8'd1;
  localparam logic [7:0] OP_ADD       = 8'd2;
  localparam logic [7:0] OP_SUB       = 8'd3;
  localparam logic [7:0] OP_XOR       = 8'd4;
  localparam logic [7:0] OP_MAX_VALID = 8'd4;

  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  function automatic logic op_is_valid(input logic [7:0] op);
    return (op <= OP_MAX_VALID);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DATA_W register file.
//   clk, rst          clock, synchronous active-high reset (clears every entry)
//   i_we/i_waddr/i_wdata   single synchronous write port
//   i_raddr_a/o_rdata_a    asynchronous read port A
//   i_raddr_b/o_rdata_b    asynchronous read port B
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREGS  = 4,
  parameter  int DATA_W = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RA_W-1:0]   i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [RA_W-1:0]   i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [NREGS-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one instruction at a time through an external
// combinational Alu.
//   clk, rst                      clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data         direct register load (honoured in IDLE only)
//   instr_valid/instr_ready       instruction handshake
//   instr_op/rd/rs1/rs2           opcode and register addresses
//   alu_opcode/alu_a/alu_b        registered Alu inputs
//   alu_result/zero/carry/negative Alu outputs, captured during ISSUE
//   done_valid/done_ready         completion handshake
//   done_result/done_err          captured result, unsupported-opcode marker
//   flags                         {Z,C,N} status register
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int NREGS  = 4,
  parameter  int DATA_W = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  output logic [7:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_negative,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [DATA_W-1:0] done_result,
  output logic              done_err,
  output logic [2:0]        flags
);

  state_t            r_state, w_state_nxt;
  logic [RA_W-1:0]   r_rd;

  logic              w_accept;
  logic              w_op_ok;
  logic              w_done_fire;
  logic              w_rf_we;
  logic [RA_W-1:0]   w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  // A load in the same cycle wins over an instruction offer, so back-pressure it.
  assign instr_ready = (r_state == S_IDLE) && !ld_en;
  assign w_accept    = instr_valid && instr_ready;
  assign w_op_ok     = op_is_valid(alu_opcode);
  assign w_done_fire = done_valid && done_ready;

  // Write port is shared: direct loads in IDLE, Alu writeback in ISSUE.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    if (r_state == S_IDLE && ld_en) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = ld_addr;
      w_rf_wdata = ld_data;
    end else if (r_state == S_ISSUE && w_op_ok) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_rd;
      w_rf_wdata = alu_result;
    end
  end

  alu_regfile #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (instr_rs1),
    .o_rdata_a (w_rs1_data),
    .i_raddr_b (instr_rs2),
    .o_rdata_b (w_rs2_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_ISSUE;
      S_ISSUE:                  w_state_nxt = S_RESP;
      S_RESP:  if (w_done_fire) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are sampled at accept, so rd==rs1/rs2 always sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      r_rd        <= '0;
      done_valid  <= 1'b0;
      done_result <= '0;
      done_err    <= 1'b0;
      flags       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            alu_opcode <= instr_op;
            alu_a      <= w_rs1_data;
            alu_b      <= w_rs2_data;
            r_rd       <= instr_rd;
          end
        end
        S_ISSUE: begin
          done_result <= alu_result;
          done_valid  <= 1'b1;
          done_err    <= !w_op_ok;
          if (w_op_ok) begin
            flags[FLG_Z] <= alu_zero;
            flags[FLG_C] <= alu_carry;
            flags[FLG_N] <= alu_negative;
          end
        end
        S_RESP: begin
          if (w_done_fire) done_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] alu_opcode, alu_a, alu_b, alu_result;
  logic       alu_zero, alu_carry, alu_negative;
  logic       done_valid, done_ready, done_err;
  logic [7:0] done_result;
  logic [2:0] flags;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_result(done_result), .done_err(done_err), .flags(flags)
  );

  // Combinational Alu the controller drives.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_opcode)
      8'd0: alu_result = alu_a & alu_b;
      8'd1: alu_result = alu_a | alu_b;
      8'd2: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[7:0];
        alu_carry  = alu_sum[8];
      end
      8'd3: alu_result = alu_a - alu_b;
      8'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_zero     = (alu_result == 8'h00);
    alu_negative = alu_result[7];
  end

  // Scoreboard
  typedef struct packed {
    logic [7:0] res;
    logic       err;
    logic [2:0] flg;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_rf[4];
  logic [2:0] m_flg;
  logic [7:0] last_res;
  logic       last_err;
  logic [2:0] last_flg;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference Alu behaviour: result plus {Z,C,N}.
  task automatic ref_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [2:0] f);
    logic [8:0] s;
    logic       c;
    c = 1'b0;
    case (op)
      8'd0: r = a & b;
      8'd1: r = a | b;
      8'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      8'd3: r = a - b;
      8'd4: r = a ^ b;
      default: r = 8'h00;
    endcase
    f = {(r == 8'h00), c, r[7]};
  endtask

  always @(negedge clk) begin
    if (!rst && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", done_result, e.res);
        chk("sb_err",    done_err,    e.err);
        chk("sb_flags",  flags,       e.flg);
        last_res = done_result;
        last_err = done_err;
        last_flg = flags;
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic issue(input logic [7:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2);
    int n;
    exp_t e;
    logic [7:0] r;
    logic [2:0] f;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    ref_alu(op, m_rf[rs1], m_rf[rs2], r, f);
    e.res = r;
    if (op <= 8'd4) begin
      e.err = 1'b0;
      m_rf[rd] = r;
      m_flg = f;
    end else begin
      e.err = 1'b1;
    end
    e.flg = m_flg;
    sb.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [7:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2);
    issue(op, rd, rs1, rs2);
    wait_done();
  endtask

  // Read a register back through the datapath: OR r,r -> r.
  task automatic read_reg(input logic [1:0] r);
    run(8'd1, r, r, r);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    done_ready = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flg = 3'b000;
    last_res = '0; last_err = 1'b0; last_flg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done_valid",  done_valid,  32'd0);
    chk("rst_done_result", done_result, 32'd0);
    chk("rst_done_err",    done_err,    32'd0);
    chk("rst_flags",       flags,       32'd0);
    chk("rst_alu_op",      alu_opcode,  32'd0);
    chk("rst_alu_ab",      {alu_a, alu_b}, 32'd0);
    chk("rst_instr_ready", instr_ready, 32'd1);

    // 1: OR
    load(2'd0, 8'h0F);
    load(2'd1, 8'hF0);
    run(8'd1, 2'd2, 2'd0, 2'd1);
    chk("t1_res", last_res, 32'hFF);
    chk("t1_flg", last_flg, 32'b001);
    read_reg(2'd2);
    chk("t1_r2", last_res, 32'hFF);

    // 2: ADD with carry out
    load(2'd0, 8'hC8);
    load(2'd1, 8'h64);
    run(8'd2, 2'd3, 2'd0, 2'd1);
    chk("t2_res", last_res, 32'h2C);
    chk("t2_flg", last_flg, 32'b010);
    read_reg(2'd3);
    chk("t2_r3", last_res, 32'h2C);

    // 3: SUB to zero with rd==rs1, then wrap-around
    load(2'd0, 8'h55);
    load(2'd1, 8'h55);
    run(8'd3, 2'd0, 2'd0, 2'd1);
    chk("t3_res0", last_res, 32'h00);
    chk("t3_flg0", last_flg, 32'b100);
    run(8'd3, 2'd2, 2'd0, 2'd1);
    chk("t3_res1", last_res, 32'hAB);
    chk("t3_flg1", last_flg, 32'b001);

    // 4: unsupported opcode
    run(8'h07, 2'd2, 2'd0, 2'd1);
    chk("t4_err", last_err, 32'd1);
    chk("t4_res", last_res, 32'h00);
    chk("t4_flg", last_flg, 32'b001);
    read_reg(2'd2);
    chk("t4_r2_kept", last_res, 32'hAB);

    // 5: done back-pressure, load in RESP ignored
    done_ready = 1'b0;
    issue(8'd1, 2'd1, 2'd1, 2'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_dv_hold",  done_valid,  32'd1);
      chk("t5_res_hold", done_result, 32'h55);
      chk("t5_ir_low",   instr_ready, 32'd0);
      if (i == 0) begin ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h99; end
    end
    ld_en = 1'b0;
    done_ready = 1'b1;
    wait_done();
    chk("t5_res", last_res, 32'h55);
    @(negedge clk);
    chk("t5_idle", instr_ready, 32'd1);
    read_reg(2'd3);
    chk("t5_r3_kept", last_res, 32'h2C);

    // 6a: load and instruction offered together
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h11;
    instr_valid = 1'b1; instr_op = 8'd2; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    #1 chk("t6_ir_ld", instr_ready, 32'd0);
    @(posedge clk); #1;
    ld_en = 1'b0; instr_valid = 1'b0;
    m_rf[0] = 8'h11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_accept", done_valid, 32'd0);
      chk("t6_still_idle", instr_ready, 32'd1);
    end
    read_reg(2'd0);
    chk("t6_r0_load", last_res, 32'h11);

    // 6b: reset while in ISSUE
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'd2; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_dv",  done_valid, 32'd0);
    chk("t6_rst_flg", flags,      32'd0);
    chk("t6_rst_a",   alu_a,      32'd0);
    chk("t6_rst_ir",  instr_ready, 32'd1);
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flg = 3'b000;
    read_reg(2'd2);
    chk("t6_r2_no_wb", last_res, 32'h00);
    chk("t6_flg_z",    last_flg, 32'b100);
    read_reg(2'd0);
    chk("t6_r0_clr",   last_res, 32'h00);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
